// File: rtl/io_trap_sequencer_if.sv
// Z80 I/O bus strobes and the enables that the trap sequencer returns to the register file.
interface io_trap_sequencer_if;
    logic [7:0] addr;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic       m1_n;
    logic [2:0] ctrl_in;
    logic       write_ctrl_en;
    logic       read_isr_en;
    logic       record_isr_en;
    logic       io_violation_occured;
    logic       nmi_n;
    logic       trap_overrun;

    // Bus side: drives the strobes and control contents, observes the enables.
    modport master (
        output addr, iorq_n, rd_n, wr_n, m1_n, ctrl_in,
        input  write_ctrl_en, read_isr_en, record_isr_en,
        input  io_violation_occured, nmi_n, trap_overrun
    );

    // Sequencer side.
    modport slave (
        input  addr, iorq_n, rd_n, wr_n, m1_n, ctrl_in,
        output write_ctrl_en, read_isr_en, record_isr_en,
        output io_violation_occured, nmi_n, trap_overrun
    );
endinterface

// File: rtl/io_trap_sequencer.sv
// I/O trap sequencer: synchronises Z80 strobes, classifies I/O cycles, drives the
// control/ISR register enables and raises an NMI trap on an illegal user I/O access.
module io_trap_sequencer #(
    parameter logic [7:0]  CTRL_PORT   = 8'h40,
    parameter logic [7:0]  ISR_PORT    = 8'h41,
    parameter int unsigned NMI_CYCLES  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              reset,
    io_trap_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, NMI, WAIT_ACK} state_t;

    logic [SYNC_STAGES-1:0] iorq_sync, rd_sync, wr_sync, m1_sync;
    logic                   iorq_prev;
    logic                   iorq_s, rd_s, wr_s, m1_s;
    logic                   io_start, io_end, classify;
    logic                   addr_legal, bad_access, isr_read_done;
    logic                   cls_pending;
    logic                   write_ctrl_en_q, read_isr_en_q, record_isr_en_q;
    logic                   violation_q, nmi_n_q, overrun_q;
    logic [7:0]             nmi_count;
    state_t                 state;
    logic                   unused_ctrl;

    assign unused_ctrl = ^bus.ctrl_in[2:1];

    // Strobe synchronisers plus the iorq_n edge-detect flop; strobes idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            iorq_sync <= '1;
            rd_sync   <= '1;
            wr_sync   <= '1;
            m1_sync   <= '1;
            iorq_prev <= 1'b1;
        end else begin
            iorq_sync <= {iorq_sync[SYNC_STAGES-2:0], bus.iorq_n};
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0],   bus.rd_n};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0],   bus.wr_n};
            m1_sync   <= {m1_sync[SYNC_STAGES-2:0],   bus.m1_n};
            iorq_prev <= iorq_s;
        end
    end

    assign iorq_s = iorq_sync[SYNC_STAGES-1];
    assign rd_s   = rd_sync[SYNC_STAGES-1];
    assign wr_s   = wr_sync[SYNC_STAGES-1];
    assign m1_s   = m1_sync[SYNC_STAGES-1];

    // Interrupt-acknowledge cycles (m1_n low with iorq_n) never start an I/O cycle.
    assign io_start      = iorq_prev & ~iorq_s & m1_s;
    assign io_end        = ~iorq_prev & iorq_s;
    assign classify      = (io_start | cls_pending) & ~io_end & (~rd_s | ~wr_s);
    assign addr_legal    = (bus.addr == CTRL_PORT) || (bus.addr == ISR_PORT);
    assign bad_access    = classify & bus.ctrl_in[0] & ~addr_legal;
    assign isr_read_done = io_end & read_isr_en_q;

    // Cycle classification; enables are held until iorq_n is seen high again so the
    // control write spans the asynchronous wr_n rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            cls_pending     <= 1'b0;
            write_ctrl_en_q <= 1'b0;
            read_isr_en_q   <= 1'b0;
        end else if (io_end) begin
            cls_pending     <= 1'b0;
            write_ctrl_en_q <= 1'b0;
            read_isr_en_q   <= 1'b0;
        end else if (classify) begin
            cls_pending     <= 1'b0;
            write_ctrl_en_q <= ~wr_s & (bus.addr == CTRL_PORT);
            read_isr_en_q   <= ~rd_s & (bus.addr == ISR_PORT);
        end else if (io_start) begin
            cls_pending     <= 1'b1;
        end
    end

    // Trap FSM: IDLE -> NMI (timed pulse) -> WAIT_ACK until the handler's ISR read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            nmi_count       <= 8'd0;
            record_isr_en_q <= 1'b1;
            violation_q     <= 1'b0;
            nmi_n_q         <= 1'b1;
            overrun_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    record_isr_en_q <= 1'b1;
                    if (bad_access) begin
                        state           <= NMI;
                        record_isr_en_q <= 1'b0;
                        violation_q     <= 1'b1;
                        nmi_n_q         <= 1'b0;
                        nmi_count       <= 8'(NMI_CYCLES);
                    end
                end
                NMI: begin
                    if (bad_access) overrun_q <= 1'b1;
                    if (nmi_count == 8'd1) begin
                        state   <= WAIT_ACK;
                        nmi_n_q <= 1'b1;
                    end
                    nmi_count <= nmi_count - 8'd1;
                end
                WAIT_ACK: begin
                    record_isr_en_q <= 1'b0;
                    if (bad_access) overrun_q <= 1'b1;
                    if (isr_read_done) begin
                        state           <= IDLE;
                        violation_q     <= 1'b0;
                        record_isr_en_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    nmi_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.write_ctrl_en        = write_ctrl_en_q;
    assign bus.read_isr_en          = read_isr_en_q;
    assign bus.record_isr_en        = record_isr_en_q;
    assign bus.io_violation_occured = violation_q;
    assign bus.nmi_n                = nmi_n_q;
    assign bus.trap_overrun         = overrun_q;

endmodule

// File: tb/tb_io_trap_sequencer.sv
// Directed bench for io_trap_sequencer with a small ISR capture model on the bench side.
module tb_io_trap_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] data_bus;
    logic [7:0] isr_q;
    int n_pass  = 0;
    int n_total = 0;
    int lows;

    io_trap_sequencer_if bus ();

    io_trap_sequencer #(
        .CTRL_PORT(8'h40), .ISR_PORT(8'h41), .NMI_CYCLES(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Register-file stand-in: opcode captured at m1_n rise when recording is enabled.
    initial isr_q = 8'h00;
    always @(posedge bus.m1_n) if (bus.record_isr_en === 1'b1) isr_q = data_bus;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic m1_fetch(input logic [7:0] op);
        data_bus   = op;
        bus.m1_n   = 1'b0;
        tick(2);
        bus.m1_n   = 1'b1;
        tick(2);
    endtask

    task automatic count_nmi_lows(input int cycles);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (bus.nmi_n === 1'b0) lows++;
        end
    endtask

    initial begin
        bus.addr = 8'h00; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        bus.m1_n = 1'b1;  bus.ctrl_in = 3'b000; data_bus = 8'h00;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_wr_en",   8'(bus.write_ctrl_en), 8'd0);
        chk("rst_rd_en",   8'(bus.read_isr_en), 8'd0);
        chk("rst_rec_en",  8'(bus.record_isr_en), 8'd1);
        chk("rst_flag",    8'(bus.io_violation_occured), 8'd0);
        chk("rst_nmi_n",   8'(bus.nmi_n), 8'd1);
        chk("rst_overrun", 8'(bus.trap_overrun), 8'd0);

        // Control write with protection off.
        m1_fetch(8'hD3);
        bus.addr = 8'h40; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick(3);
        chk("ctrl_wr_en_on",  8'(bus.write_ctrl_en), 8'd1);
        chk("ctrl_rd_en_off", 8'(bus.read_isr_en), 8'd0);
        tick(2);
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        tick(2);
        chk("ctrl_wr_en_span", 8'(bus.write_ctrl_en), 8'd1);
        tick(1);
        chk("ctrl_wr_en_end", 8'(bus.write_ctrl_en), 8'd0);
        chk("ctrl_nmi_idle",  8'(bus.nmi_n), 8'd1);

        // Control write with protection on is still legal.
        bus.ctrl_in = 3'b001;
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick(3);
        chk("prot_ctrl_wr_en", 8'(bus.write_ctrl_en), 8'd1);
        chk("prot_ctrl_flag",  8'(bus.io_violation_occured), 8'd0);
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        tick(4);

        // Violation: OUT (0x12) after opcode 0xD3.
        m1_fetch(8'hD3);
        bus.addr = 8'h12; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick(3);
        chk("viol_flag",   8'(bus.io_violation_occured), 8'd1);
        chk("viol_nmi_n",  8'(bus.nmi_n), 8'd0);
        chk("viol_rec_en", 8'(bus.record_isr_en), 8'd0);
        chk("viol_wr_en",  8'(bus.write_ctrl_en), 8'd0);
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        lows = 1;
        for (int g = 0; g < 40 && bus.nmi_n === 1'b0; g++) begin
            tick(1);
            if (bus.nmi_n === 1'b0) lows++;
        end
        chk("nmi_width", 8'(lows), 8'd8);
        chk("isr_opcode", isr_q, 8'hD3);

        // Second violation while waiting for the handler.
        m1_fetch(8'hDB);
        bus.addr = 8'h20; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        tick(3);
        chk("ovr_flag",    8'(bus.trap_overrun), 8'd1);
        chk("ovr_rec_en",  8'(bus.record_isr_en), 8'd0);
        chk("ovr_nmi_n",   8'(bus.nmi_n), 8'd1);
        chk("ovr_rd_en",   8'(bus.read_isr_en), 8'd0);
        bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
        count_nmi_lows(10);
        chk("ovr_no_nmi", 8'(lows), 8'd0);
        chk("ovr_isr_kept", isr_q, 8'hD3);
        chk("ovr_viol_kept", 8'(bus.io_violation_occured), 8'd1);

        // Handler IN A,(0x41); rd_n arrives after iorq_n to exercise late classification.
        m1_fetch(8'hDB);
        chk("ack_isr_kept", isr_q, 8'hD3);
        bus.addr = 8'h41; bus.iorq_n = 1'b0;
        tick(3);
        chk("ack_rd_pending", 8'(bus.read_isr_en), 8'd0);
        bus.rd_n = 1'b0;
        tick(3);
        chk("ack_rd_en",     8'(bus.read_isr_en), 8'd1);
        chk("ack_flag_read", 8'(bus.io_violation_occured), 8'd1);
        bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
        tick(2);
        chk("ack_rd_en_span", 8'(bus.read_isr_en), 8'd1);
        tick(1);
        chk("ack_rd_en_end",  8'(bus.read_isr_en), 8'd0);
        chk("ack_flag_clr",   8'(bus.io_violation_occured), 8'd0);
        chk("ack_rec_en",     8'(bus.record_isr_en), 8'd1);
        chk("ack_ovr_sticky", 8'(bus.trap_overrun), 8'd1);
        m1_fetch(8'hAA);
        chk("ack_isr_resume", isr_q, 8'hAA);

        // Interrupt-acknowledge cycle to an illegal-looking address.
        bus.addr = 8'h12; bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        tick(5);
        chk("inta_wr_en", 8'(bus.write_ctrl_en), 8'd0);
        chk("inta_rd_en", 8'(bus.read_isr_en), 8'd0);
        chk("inta_flag",  8'(bus.io_violation_occured), 8'd0);
        chk("inta_nmi_n", 8'(bus.nmi_n), 8'd1);
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
        tick(3);
        chk("inta_flag_after", 8'(bus.io_violation_occured), 8'd0);

        // Reset in the middle of an NMI pulse.
        m1_fetch(8'hD3);
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick(3);
        chk("rstmid_nmi_low", 8'(bus.nmi_n), 8'd0);
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rstmid_nmi_n",   8'(bus.nmi_n), 8'd1);
        chk("rstmid_flag",    8'(bus.io_violation_occured), 8'd0);
        chk("rstmid_rec_en",  8'(bus.record_isr_en), 8'd1);
        chk("rstmid_overrun", 8'(bus.trap_overrun), 8'd0);
        tick(2);
        reset = 1'b0;
        count_nmi_lows(10);
        chk("rstmid_no_nmi", 8'(lows), 8'd0);
        bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick(3);
        chk("rstmid_idle_retrap", 8'(bus.nmi_n), 8'd0);
        bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
